// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single write port of the 24-bit async FIFO between two
//   producers. Each producer requests a burst of N words, and bursts are
//   granted round-robin. Granted data is streamed into winc/wdata and
//   throttled by the FIFO full flag. All logic runs in the CLK write domain.
//
// Ports
//   CLK, RST                write clock, synchronous active-high reset
//   req0/len0/wdata0/valid0 producer 0 request, burst length, data, valid
//   ready0/gnt0/done0       producer 0 beat accept, burst grant, done pulse
//   req1 ... done1          same for producer 1
//   winc, wdata             FIFO write strobe and data (wdata is 0 when idle)
//   wfull                   [1]=full (blocks beats), [0]=almost-full (unused)
//   busy                    high whenever the arbiter is not in IDLE
//   wr_count                free-running count of words written, wraps

module fifo_wr_arbiter #(
    parameter int DW   = 24,
    parameter int LENW = 5,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req0,
    input  logic [LENW-1:0] len0,
    input  logic [DW-1:0]   wdata0,
    input  logic            valid0,
    output logic            ready0,
    output logic            gnt0,
    output logic            done0,
    input  logic            req1,
    input  logic [LENW-1:0] len1,
    input  logic [DW-1:0]   wdata1,
    input  logic            valid1,
    output logic            ready1,
    output logic            gnt1,
    output logic            done1,
    output logic            winc,
    output logic [DW-1:0]   wdata,
    input  logic [1:0]      wfull,
    output logic            busy,
    output logic [CNTW-1:0] wr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST0,
        S_BURST1,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_rr;       // producer preferred when both request
    logic            r_owner;    // producer owning the current burst
    logic [LENW-1:0] r_cnt;      // beats still to transfer
    logic            r_gnt0;
    logic            r_gnt1;
    logic            r_done0;
    logic            r_done1;
    logic            r_busy;
    logic [CNTW-1:0] r_wr_count;

    logic            w_ready0;
    logic            w_ready1;
    logic            w_beat0;
    logic            w_beat1;
    logic            w_beat;
    logic            w_pick1;
    logic [LENW-1:0] w_glen;
    logic [DW-1:0]   w_wdata;
    logic            w_unused_afull;

    // Almost-full is informational only; the arbiter throttles on full alone.
    assign w_unused_afull = wfull[0];

    // Ready is combinational so a beat can issue in the same cycle full drops.
    assign w_ready0 = (r_state == S_BURST0) && !wfull[1];
    assign w_ready1 = (r_state == S_BURST1) && !wfull[1];
    assign w_beat0  = w_ready0 && valid0;
    assign w_beat1  = w_ready1 && valid1;
    assign w_beat   = w_beat0 || w_beat1;

    // Producer 1 wins if it is the only requester or holds the round-robin turn.
    assign w_pick1  = req1 && (!req0 || r_rr);
    assign w_glen   = w_pick1 ? len1 : len0;

    always_comb begin
        w_wdata = '0;
        if (w_beat0) begin
            w_wdata = wdata0;
        end else if (w_beat1) begin
            w_wdata = wdata1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_rr       <= 1'b0;
            r_owner    <= 1'b0;
            r_cnt      <= '0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (w_beat) begin
                r_wr_count <= r_wr_count + CNTW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_owner <= w_pick1;
                        r_gnt0  <= !w_pick1;
                        r_gnt1  <= w_pick1;
                        r_busy  <= 1'b1;
                        r_cnt   <= w_glen;
                        // A zero-length burst skips straight to DONE, so the
                        // grant and the done pulse share that single cycle.
                        if (w_glen == '0) begin
                            r_state <= S_DONE;
                            r_done0 <= !w_pick1;
                            r_done1 <= w_pick1;
                        end else begin
                            r_state <= w_pick1 ? S_BURST1 : S_BURST0;
                        end
                    end
                end
                S_BURST0, S_BURST1: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt - LENW'(1);
                        if (r_cnt == LENW'(1)) begin
                            r_state <= S_DONE;
                            r_gnt0  <= 1'b0;
                            r_gnt1  <= 1'b0;
                            r_done0 <= !r_owner;
                            r_done1 <= r_owner;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_rr    <= !r_owner;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready0   = w_ready0;
    assign ready1   = w_ready1;
    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign winc     = w_beat;
    assign wdata    = w_wdata;
    assign busy     = r_busy;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: randomized producers and FIFO-full
// stimulus; expected beats and grant order come from a round-robin burst
// model and are checked by an independent monitor process.

module tb_fifo_wr_arbiter;

    localparam int DW   = 24;
    localparam int LENW = 5;
    localparam int CNTW = 16;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            req0 = 1'b0, req1 = 1'b0;
    logic [LENW-1:0] len0 = '0, len1 = '0;
    logic [DW-1:0]   wdata0 = '0, wdata1 = '0;
    logic            valid0 = 1'b0, valid1 = 1'b0;
    logic            ready0, ready1, gnt0, gnt1, done0, done1;
    logic            winc, busy;
    logic [DW-1:0]   wdata;
    logic [1:0]      wfull = 2'b00;
    logic [CNTW-1:0] wr_count;

    always #5 CLK = ~CLK;

    fifo_wr_arbiter #(.DW(DW), .LENW(LENW), .CNTW(CNTW)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .len0(len0), .wdata0(wdata0), .valid0(valid0),
        .ready0(ready0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .len1(len1), .wdata1(wdata1), .valid1(valid1),
        .ready1(ready1), .gnt1(gnt1), .done1(done1),
        .winc(winc), .wdata(wdata), .wfull(wfull),
        .busy(busy), .wr_count(wr_count)
    );

    typedef struct {
        bit            id;
        logic [DW-1:0] data;
    } beat_t;

    int checks = 0;
    int failures = 0;

    beat_t         exp_q[$];    // expected FIFO write stream, in grant order
    bit            exp_gnt[$];  // expected producer order of grants
    logic [DW-1:0] pq0[$], pq1[$];
    int            plan0[$], plan1[$];
    bit            plan_fixed = 1'b0;
    int            model_rr = 0;
    int            model_words = 0;

    int done_cnt0 = 0, done_cnt1 = 0;
    bit mon_en = 1'b0;

    int vmode = 0;              // 0 always valid, 1 random, 2 pattern on p0
    int fmode = 0;              // 0 never full, 1 random full
    int vpat[5] = '{1, 0, 0, 1, 1};
    int vidx = 0;
    int fire_cnt = 0;
    int stall_after = 0;        // 0 disables the scheduled full stall
    int stall_left = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs on the falling edge, then record handshakes.
    task automatic cycle();
        logic v0, v1;
        @(negedge CLK);
        v0 = pq0.size() > 0;
        v1 = pq1.size() > 0;
        if (vmode == 1) begin
            v0 = v0 && ($urandom_range(0, 9) < 7);
            v1 = v1 && ($urandom_range(0, 9) < 7);
        end else if (vmode == 2 && gnt0) begin
            v0 = v0 && (vpat[vidx % 5] != 0);
            vidx++;
        end
        valid0 = v0;
        valid1 = v1;
        wdata0 = v0 ? pq0[0] : DW'($urandom);
        wdata1 = v1 ? pq1[0] : DW'($urandom);
        if (stall_left > 0) begin
            wfull = {1'b1, 1'($urandom)};
            stall_left--;
        end else if (fmode == 1) begin
            wfull = {($urandom_range(0, 9) < 3), 1'($urandom)};
        end else begin
            wfull = {1'b0, 1'($urandom)};
        end
        #1;
        if (valid0 && ready0) begin
            void'(pq0.pop_front());
            fire_cnt++;
            if (fire_cnt == stall_after) stall_left = 4;
        end
        if (valid1 && ready1) begin
            void'(pq1.pop_front());
            fire_cnt++;
            if (fire_cnt == stall_after) stall_left = 4;
        end
    endtask

    // Round-robin burst model: producer order and the exact word stream.
    task automatic plan_bursts();
        int a = 0;
        int b = 0;
        int pick, len;
        logic [DW-1:0] d;
        while (a < plan0.size() || b < plan1.size()) begin
            if (a < plan0.size() && b < plan1.size()) pick = model_rr;
            else if (a < plan0.size()) pick = 0;
            else pick = 1;
            if (pick == 0) begin len = plan0[a]; a++; end
            else begin len = plan1[b]; b++; end
            exp_gnt.push_back(pick[0]);
            for (int w = 0; w < len; w++) begin
                d = plan_fixed ? DW'(w + 1) : DW'($urandom);
                if (pick == 0) pq0.push_back(d); else pq1.push_back(d);
                exp_q.push_back('{id: pick[0], data: d});
            end
            model_words += len;
            model_rr = 1 - pick;
        end
    endtask

    task automatic run_plan(input int budget);
        int n0 = plan0.size();
        int n1 = plan1.size();
        int b0 = done_cnt0;
        int b1 = done_cnt1;
        int g0 = 0, g1 = 0, c = 0;
        logic sp0 = 1'b0, sp1 = 1'b0;
        plan_bursts();
        len0 = (n0 > 0) ? LENW'(plan0[0]) : '0;
        len1 = (n1 > 0) ? LENW'(plan1[0]) : '0;
        req0 = n0 > 0;
        req1 = n1 > 0;
        while (c < budget && !((done_cnt0 - b0) == n0 && (done_cnt1 - b1) == n1)) begin
            cycle();
            c++;
            if (gnt0 && !sp0) begin
                g0++;
                if (g0 >= n0) req0 = 1'b0; else len0 = LENW'(plan0[g0]);
            end
            if (gnt1 && !sp1) begin
                g1++;
                if (g1 >= n1) req1 = 1'b0; else len1 = LENW'(plan1[g1]);
            end
            sp0 = gnt0;
            sp1 = gnt1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("bursts_within_budget", c < budget, 1);
        repeat (3) cycle();
        chk("done0_pulses", done_cnt0 - b0, n0);
        chk("done1_pulses", done_cnt1 - b1, n1);
        chk("beats_outstanding", exp_q.size(), 0);
        chk("grants_outstanding", exp_gnt.size(), 0);
        chk("wr_count", wr_count, model_words % (1 << CNTW));
        chk("busy_after_bursts", busy, 0);
        plan0.delete();
        plan1.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_winc", winc, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_ready0", ready0, 0);
        chk("rst_ready1", ready1, 0);
        chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_count", wr_count, 0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        cycle();
        mon_en = 1'b1;
        check_reset_outputs();
        cycle();
        RST = 1'b0;
        pq0.delete();
        pq1.delete();
        exp_q.delete();
        exp_gnt.delete();
        model_rr = 0;
        model_words = 0;
    endtask

    // Monitor: consumes expected beats and grants as the DUT presents them.
    initial begin
        beat_t e;
        logic pg0 = 1'b0, pg1 = 1'b0;
        wait (mon_en);
        forever begin
            @(negedge CLK);
            #2;
            if (winc) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wdata", wdata, e.data);
                    chk("beat_owner_gnt", e.id ? gnt1 : gnt0, 1);
                end
            end else begin
                chk("wdata_zero_when_idle", wdata, 0);
            end
            chk("gnt_exclusive", gnt0 & gnt1, 0);
            chk("no_winc_when_full", winc & wfull[1], 0);
            chk("winc_needs_handshake", winc & !((valid0 & ready0) | (valid1 & ready1)), 0);
            chk("ready_needs_gnt", (ready0 & !gnt0) | (ready1 & !gnt1), 0);
            if (wfull[1]) chk("ready_low_when_full", ready0 | ready1, 0);
            if ((gnt0 && !pg0) || (gnt1 && !pg1)) begin
                chk("grant_expected", exp_gnt.size() > 0, 1);
                if (exp_gnt.size() > 0) chk("grant_order", gnt1, exp_gnt.pop_front());
            end
            if (done0) done_cnt0++;
            if (done1) done_cnt1++;
            pg0 = gnt0;
            pg1 = gnt1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int dc0, dc1, c;
        do_reset();

        // Single 3-word burst with fixed data 1,2,3 and exact latencies.
        plan_fixed = 1'b1;
        plan0.push_back(3);
        plan_bursts();
        plan0.delete();
        plan_fixed = 1'b0;
        len0 = 5'd3;
        req0 = 1'b1;
        cycle();
        chk("t1_gnt0_next_cycle", gnt0, 1);
        chk("t1_first_beat_next_cycle", winc, 1);
        chk("t1_busy", busy, 1);
        req0 = 1'b0;
        cycle();
        cycle();
        cycle();
        chk("t1_done0_after_last_beat", done0, 1);
        chk("t1_gnt0_dropped", gnt0, 0);
        chk("t1_no_winc_in_done", winc, 0);
        cycle();
        chk("t1_done0_one_cycle", done0, 0);
        chk("t1_idle_after_done", busy, 0);
        chk("t1_wr_count", wr_count, 3);
        chk("t1_beats_outstanding", exp_q.size(), 0);

        // Both producers held, two bursts of 2 each: strict alternation.
        do_reset();
        plan0 = '{2, 2};
        plan1 = '{2, 2};
        run_plan(200);

        // Burst of 5 with a 4-cycle full stall after beat 2.
        fire_cnt = 0;
        stall_after = 2;
        plan0.push_back(5);
        run_plan(200);
        stall_after = 0;

        // Zero-length burst on producer 1, then contention must favour 0.
        plan1.push_back(0);
        run_plan(50);
        plan0.push_back(1);
        plan1.push_back(1);
        run_plan(100);

        // Reset in the middle of a 6-word burst, then a clean burst.
        plan0.push_back(6);
        plan_bursts();
        plan0.delete();
        len0 = 5'd6;
        req0 = 1'b1;
        fire_cnt = 0;
        c = 0;
        while (fire_cnt < 2 && c < 50) begin
            cycle();
            c++;
            if (gnt0) req0 = 1'b0;
        end
        chk("t5_beats_before_reset", fire_cnt, 2);
        dc0 = done_cnt0;
        dc1 = done_cnt1;
        do_reset();
        repeat (3) cycle();
        chk("t5_no_done0_after_abort", done_cnt0, dc0);
        chk("t5_no_done1_after_abort", done_cnt1, dc1);
        plan0.push_back(4);
        run_plan(200);

        // Valid gaps 1,0,0,1,1 on a 3-word burst.
        vmode = 2;
        vidx = 0;
        plan0.push_back(3);
        run_plan(100);
        vmode = 0;

        // Randomized contention, lengths, valid gaps and full flag.
        vmode = 1;
        fmode = 1;
        for (int it = 0; it < 12; it++) begin
            int n0, n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range((n0 == 0) ? 1 : 0, 3);
            for (int k = 0; k < n0; k++)
                plan0.push_back((it == 0 && k == 0) ? 31 : $urandom_range(0, 8));
            for (int k = 0; k < n1; k++)
                plan1.push_back($urandom_range(0, 8));
            run_plan(1500);
        end
        vmode = 0;
        fmode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
